// File: rtl/debug_hart_run_ctrl_pkg.sv
// Shared debug definitions: run-control state encodings,
// DM status bit positions and debug cause codes.
package debug_hart_run_ctrl_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_HALT_REQ   = 2'd1;
  localparam logic [1:0] ST_HALTED     = 2'd2;
  localparam logic [1:0] ST_RESUME_REQ = 2'd3;

  localparam int unsigned STAT_HALTED    = 0;
  localparam int unsigned STAT_RUNNING   = 1;
  localparam int unsigned STAT_RESUMEACK = 2;
  localparam int unsigned STAT_TIMEOUT   = 3;

  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_EBREAK       = 3'd1,
    CAUSE_BREAKPOINT   = 3'd2,
    CAUSE_HALTREQ      = 3'd3,
    CAUSE_STEP         = 3'd4,
    CAUSE_RESETHALTREQ = 3'd5
  } dbg_cause_e;

  function automatic logic st_is_halted(
    input logic [1:0] st
  );
    return (st == ST_HALTED) ||
           (st == ST_RESUME_REQ);
  endfunction

endpackage

// File: rtl/debug_hart_run_ctrl_if.sv
// Debug Module side of the hart run-control agent:
// requests from the DM and status back to it.
interface debug_hart_run_ctrl_if;

  logic dm_haltreq_i;
  logic dm_resumereq_i;
  logic dm_resethaltreq_i;
  logic dm_clr_timeout_i;
  logic dm_halted_o;
  logic dm_running_o;
  logic dm_resumeack_o;
  logic dm_timeout_o;

  modport master (
    output dm_haltreq_i,
    output dm_resumereq_i,
    output dm_resethaltreq_i,
    output dm_clr_timeout_i,
    input  dm_halted_o,
    input  dm_running_o,
    input  dm_resumeack_o,
    input  dm_timeout_o
  );

  modport slave (
    input  dm_haltreq_i,
    input  dm_resumereq_i,
    input  dm_resethaltreq_i,
    input  dm_clr_timeout_i,
    output dm_halted_o,
    output dm_running_o,
    output dm_resumeack_o,
    output dm_timeout_o
  );

endinterface

// File: rtl/debug_hart_run_ctrl_retry_timer.sv
// Halt-request retry timer: cycle counter per strobe
// and count of re-strobes already issued.
module debug_hart_run_ctrl_retry_timer #(
  parameter int unsigned RETRY_CYCLES = 64,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start,
  input  logic run,
  output logic expire,
  output logic exhausted
);

  localparam int unsigned CW = $clog2(RETRY_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(RETRY_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  logic [CW-1:0] cyc_cnt;
  logic [RW-1:0] retry_cnt;

  assign expire    = (cyc_cnt == CYC_LAST);
  assign exhausted = (retry_cnt >= RTY_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt   <= '0;
      retry_cnt <= '0;
    end else if (start) begin
      cyc_cnt   <= '0;
      retry_cnt <= '0;
    end else if (run) begin
      if (expire) begin
        cyc_cnt <= '0;
        if (!exhausted) retry_cnt <= retry_cnt + 1'b1;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_hart_run_ctrl.sv
// Hart-side run control: turns DM halt/resume requests
// into debug strobes and resume requests, reports status.
module debug_hart_run_ctrl
  import debug_hart_run_ctrl_pkg::*;
#(
  parameter int unsigned RETRY_CYCLES = 64,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hart_halted_i,
  output logic debug_strobe_o,
  output logic resume_req_o,
  debug_hart_run_ctrl_if.slave dm
);

  logic [1:0] state_q, state_d;
  logic strobe_d, resume_d, ack_d;
  logic tmo_set, start, run;
  logic rst_pending_q, req_rst_q, req_rst_d;
  logic expire, exhausted, rst_halt;

  assign rst_halt = rst_pending_q & dm.dm_resethaltreq_i;
  assign run      = (state_q == ST_HALT_REQ);

  debug_hart_run_ctrl_retry_timer #(
    .RETRY_CYCLES (RETRY_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (start),
    .run       (run),
    .expire    (expire),
    .exhausted (exhausted)
  );

  always_comb begin
    state_d   = state_q;
    strobe_d  = 1'b0;
    resume_d  = resume_req_o;
    ack_d     = dm.dm_resumeack_o;
    tmo_set   = 1'b0;
    start     = 1'b0;
    req_rst_d = req_rst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hart_halted_i) begin
          state_d = ST_HALTED;
        end else if (dm.dm_haltreq_i | rst_halt) begin
          state_d   = ST_HALT_REQ;
          strobe_d  = 1'b1;
          start     = 1'b1;
          req_rst_d = rst_halt;
        end
      end
      ST_HALT_REQ: begin
        if (hart_halted_i) begin
          state_d = ST_HALTED;
        end else if (!dm.dm_haltreq_i && !req_rst_q) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          if (exhausted) begin
            tmo_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            strobe_d = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        // an external resume (not via DM) leaves resumeack alone
        if (!hart_halted_i) begin
          state_d = ST_IDLE;
        end else if (dm.dm_resumereq_i && !dm.dm_haltreq_i) begin
          state_d  = ST_RESUME_REQ;
          resume_d = 1'b1;
          ack_d    = 1'b0;
        end
      end
      ST_RESUME_REQ: begin
        if (!hart_halted_i) begin
          state_d  = ST_IDLE;
          resume_d = 1'b0;
          ack_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= ST_IDLE;
      debug_strobe_o    <= 1'b0;
      resume_req_o      <= 1'b0;
      dm.dm_resumeack_o <= 1'b0;
      dm.dm_timeout_o   <= 1'b0;
      rst_pending_q     <= 1'b1;
      req_rst_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      debug_strobe_o    <= strobe_d;
      resume_req_o      <= resume_d;
      dm.dm_resumeack_o <= ack_d;
      rst_pending_q     <= 1'b0;
      req_rst_q         <= req_rst_d;
      // a new timeout beats a simultaneous clear
      dm.dm_timeout_o   <= tmo_set |
        (dm.dm_timeout_o & ~dm.dm_clr_timeout_i);
    end
  end

  assign dm.dm_halted_o  = st_is_halted(state_q);
  assign dm.dm_running_o = ~st_is_halted(state_q);

endmodule

// File: tb/tb_debug_hart_run_ctrl.sv
// Directed bench for debug_hart_run_ctrl with
// RETRY_CYCLES=4, MAX_RETRIES=2.
module tb_debug_hart_run_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic hart_halted_i;
  logic debug_strobe_o;
  logic resume_req_o;
  int checks = 0;
  int failures = 0;

  debug_hart_run_ctrl_if dmif ();

  debug_hart_run_ctrl #(
    .RETRY_CYCLES (4),
    .MAX_RETRIES  (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .hart_halted_i  (hart_halted_i),
    .debug_strobe_o (debug_strobe_o),
    .resume_req_o   (resume_req_o),
    .dm             (dmif)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    hart_halted_i          = 1'b0;
    dmif.dm_haltreq_i      = 1'b0;
    dmif.dm_resumereq_i    = 1'b0;
    dmif.dm_resethaltreq_i = 1'b0;
    dmif.dm_clr_timeout_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b1;
    clear_inputs();
    #1 rst_ni = 1'b0;
    #2;
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", debug_strobe_o); end
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL reset_resume got=%b exp=0", resume_req_o); end
    checks++; if (dmif.dm_halted_o !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", dmif.dm_halted_o); end
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL reset_running got=%b exp=1", dmif.dm_running_o); end
    checks++; if (dmif.dm_resumeack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", dmif.dm_resumeack_o); end
    checks++; if (dmif.dm_timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", dmif.dm_timeout_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_halt;
    dmif.dm_haltreq_i = 1'b1;
    tick();
    checks++; if (debug_strobe_o !== 1'b1) begin failures++; $display("FAIL halt_strobe_t1 got=%b exp=1", debug_strobe_o); end
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL halt_running_t1 got=%b exp=1", dmif.dm_running_o); end
    tick();
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL halt_strobe_t2 got=%b exp=0", debug_strobe_o); end
    hart_halted_i = 1'b1;
    tick();
    checks++; if (dmif.dm_halted_o !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", dmif.dm_halted_o); end
    checks++; if (dmif.dm_running_o !== 1'b0) begin failures++; $display("FAIL halt_running got=%b exp=0", dmif.dm_running_o); end
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL halt_strobe_t3 got=%b exp=0", debug_strobe_o); end
    dmif.dm_haltreq_i = 1'b0;
    tick();
  endtask

  task automatic test_resume;
    int highs;
    highs = 0;
    dmif.dm_resumereq_i = 1'b1;
    tick();
    dmif.dm_resumereq_i = 1'b0;
    checks++; if (dmif.dm_resumeack_o !== 1'b0) begin failures++; $display("FAIL resume_ack_clr got=%b exp=0", dmif.dm_resumeack_o); end
    checks++; if (dmif.dm_halted_o !== 1'b1) begin failures++; $display("FAIL resume_halted got=%b exp=1", dmif.dm_halted_o); end
    for (int t = 1; t <= 3; t++) begin
      if (resume_req_o === 1'b1) highs++;
      if (t == 3) hart_halted_i = 1'b0;
      if (t < 3) tick();
    end
    tick();
    checks++; if (highs !== 3) begin failures++; $display("FAIL resume_high_cycles got=%0d exp=3", highs); end
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL resume_drop got=%b exp=0", resume_req_o); end
    checks++; if (dmif.dm_resumeack_o !== 1'b1) begin failures++; $display("FAIL resume_ack got=%b exp=1", dmif.dm_resumeack_o); end
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", dmif.dm_running_o); end
  endtask

  task automatic test_resume_vs_haltreq;
    hart_halted_i = 1'b1;
    tick();
    checks++; if (dmif.dm_halted_o !== 1'b1) begin failures++; $display("FAIL ext_halt_halted got=%b exp=1", dmif.dm_halted_o); end
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL ext_halt_strobe got=%b exp=0", debug_strobe_o); end
    dmif.dm_haltreq_i   = 1'b1;
    dmif.dm_resumereq_i = 1'b1;
    tick();
    dmif.dm_resumereq_i = 1'b0;
    dmif.dm_haltreq_i   = 1'b0;
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL both_resume got=%b exp=0", resume_req_o); end
    checks++; if (dmif.dm_halted_o !== 1'b1) begin failures++; $display("FAIL both_halted got=%b exp=1", dmif.dm_halted_o); end
    checks++; if (dmif.dm_resumeack_o !== 1'b1) begin failures++; $display("FAIL both_ack got=%b exp=1", dmif.dm_resumeack_o); end
    tick();
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL both_resume_t2 got=%b exp=0", resume_req_o); end
    hart_halted_i = 1'b0;
    tick();
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL ext_fall_running got=%b exp=1", dmif.dm_running_o); end
    checks++; if (dmif.dm_resumeack_o !== 1'b1) begin failures++; $display("FAIL ext_fall_ack got=%b exp=1", dmif.dm_resumeack_o); end
  endtask

  task automatic test_abort;
    int n;
    n = 0;
    dmif.dm_haltreq_i = 1'b1;
    tick();
    checks++; if (debug_strobe_o !== 1'b1) begin failures++; $display("FAIL abort_strobe got=%b exp=1", debug_strobe_o); end
    dmif.dm_haltreq_i = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (debug_strobe_o === 1'b1) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL abort_extra_strobes got=%0d exp=0", n); end
    checks++; if (dmif.dm_timeout_o !== 1'b0) begin failures++; $display("FAIL abort_timeout got=%b exp=0", dmif.dm_timeout_o); end
  endtask

  task automatic test_timeout;
    logic exp_s;
    logic exp_t;
    dmif.dm_haltreq_i = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      exp_s = (t == 1) || (t == 5) || (t == 9);
      exp_t = (t >= 13);
      checks++; if (debug_strobe_o !== exp_s) begin failures++; $display("FAIL tmo_strobe_t%0d got=%b exp=%b", t, debug_strobe_o, exp_s); end
      checks++; if (dmif.dm_timeout_o !== exp_t) begin failures++; $display("FAIL tmo_flag_t%0d got=%b exp=%b", t, dmif.dm_timeout_o, exp_t); end
      dmif.dm_clr_timeout_i = (t == 12);
    end
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL tmo_running got=%b exp=1", dmif.dm_running_o); end
    dmif.dm_haltreq_i = 1'b0;
    tick();
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL tmo_strobe_t14 got=%b exp=0", debug_strobe_o); end
    checks++; if (dmif.dm_timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", dmif.dm_timeout_o); end
    dmif.dm_clr_timeout_i = 1'b1;
    tick();
    dmif.dm_clr_timeout_i = 1'b0;
    checks++; if (dmif.dm_timeout_o !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", dmif.dm_timeout_o); end
  endtask

  task automatic test_resethaltreq;
    logic exp_s;
    clear_inputs();
    rst_ni = 1'b0;
    dmif.dm_resethaltreq_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    #1;
    checks++; if (debug_strobe_o !== 1'b0) begin failures++; $display("FAIL rhr_strobe_t0 got=%b exp=0", debug_strobe_o); end
    tick();
    checks++; if (debug_strobe_o !== 1'b1) begin failures++; $display("FAIL rhr_strobe_t1 got=%b exp=1", debug_strobe_o); end
    dmif.dm_resethaltreq_i = 1'b0;
    for (int t = 2; t <= 5; t++) begin
      tick();
      exp_s = (t == 5);
      checks++; if (debug_strobe_o !== exp_s) begin failures++; $display("FAIL rhr_strobe_t%0d got=%b exp=%b", t, debug_strobe_o, exp_s); end
    end
    hart_halted_i = 1'b1;
    tick();
    checks++; if (dmif.dm_halted_o !== 1'b1) begin failures++; $display("FAIL rhr_halted got=%b exp=1", dmif.dm_halted_o); end
    hart_halted_i = 1'b0;
    tick();
  endtask

  task automatic test_rst_pending_clears;
    int n;
    n = 0;
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    dmif.dm_resethaltreq_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (debug_strobe_o === 1'b1) n++;
    end
    dmif.dm_resethaltreq_i = 1'b0;
    checks++; if (n !== 0) begin failures++; $display("FAIL late_rhr_strobes got=%0d exp=0", n); end
  endtask

  task automatic test_reset_mid_resume;
    hart_halted_i = 1'b1;
    tick();
    dmif.dm_resumereq_i = 1'b1;
    tick();
    dmif.dm_resumereq_i = 1'b0;
    checks++; if (resume_req_o !== 1'b1) begin failures++; $display("FAIL midrst_resume_pre got=%b exp=1", resume_req_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL midrst_resume_async got=%b exp=0", resume_req_o); end
    checks++; if (dmif.dm_halted_o !== 1'b0) begin failures++; $display("FAIL midrst_halted got=%b exp=0", dmif.dm_halted_o); end
    hart_halted_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    checks++; if (dmif.dm_running_o !== 1'b1) begin failures++; $display("FAIL midrst_running got=%b exp=1", dmif.dm_running_o); end
    checks++; if (dmif.dm_halted_o !== 1'b0) begin failures++; $display("FAIL midrst_halted_post got=%b exp=0", dmif.dm_halted_o); end
    checks++; if (dmif.dm_resumeack_o !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", dmif.dm_resumeack_o); end
    checks++; if (dmif.dm_timeout_o !== 1'b0) begin failures++; $display("FAIL midrst_timeout got=%b exp=0", dmif.dm_timeout_o); end
    checks++; if (resume_req_o !== 1'b0) begin failures++; $display("FAIL midrst_resume_post got=%b exp=0", resume_req_o); end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_resume();
    test_resume_vs_haltreq();
    test_abort();
    test_timeout();
    test_resethaltreq();
    test_rst_pending_clears();
    test_reset_mid_resume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
